rst_seq_ctrl: RTL and testbench

- Parametrised successor to the single-output reset-to-valid block.
- Takes the board-level asynchronous reset and applies it immediately; reset release is synchronised to clk.
- After release, a hold-off period runs, then N_CH downstream reset outputs are released in a fixed order, then valid is raised.
- Also accepts a synchronous software reset request, filtered for minimum width. Sits at the top of each clock domain, feeding its local reset tree.

---
 rtl/rst_seq_pkg.sv | 27 ++
 rtl/rst_sync_cell.sv | 25 ++
 rtl/rst_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Imported by rst_sync_cell and rst_seq_ctrl.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        RESET,
        HOLD,
        SEQ,
        RUN,
        SOFT
    } state_t;

    function automatic int cnt_width(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sync_cell.sv
// Async-assert / sync-deassert reset flop chain.
// Output falls immediately with rst_n and rises STAGES clocks after release.
module rst_sync_cell
    import rst_seq_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= (r_chain << 1) | STAGES'(1);
        end
    end

    assign rst_sync_n = r_chain[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronised release, hold-off, ordered channel
// release, valid, and a width-filtered software reset request.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int N_CH        = 3,
    parameter int STEP_CYCLES = 2,
    parameter int MIN_REQ     = 3,
    parameter int SOFT_CYCLES = 5,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_rst_req,
    output logic [N_CH-1:0]  rst_out_n,
    output logic             valid,
    output logic             busy,
    output logic             req_reject,
    output logic [CNT_W-1:0] soft_cnt
);

    localparam int CW = cnt_width(HOLD_CYCLES, STEP_CYCLES,
                                  SOFT_CYCLES, MIN_REQ);
    localparam int IW = $clog2(N_CH + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST  = CW'(MIN_REQ - 1);
    localparam logic [IW-1:0] CH_N      = IW'(N_CH);

    logic w_sync_n;

    state_t           r_state;
    logic [CW-1:0]    r_hold_cnt;
    logic [CW-1:0]    r_step_cnt;
    logic [CW-1:0]    r_soft_tmr;
    logic [CW-1:0]    r_req_cnt;
    logic [IW-1:0]    r_idx;
    logic [N_CH-1:0]  r_rst_out_n;
    logic             r_valid;
    logic             r_busy;
    logic             r_req_reject;
    logic [CNT_W-1:0] r_soft_cnt;

    // The state register is the last synchroniser stage, so the
    // chain is one flop shorter and RESET->HOLD lands on edge SYNC_STAGES.
    rst_sync_cell #(
        .STAGES(SYNC_STAGES - 1)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .rst_sync_n(w_sync_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RESET;
            r_hold_cnt   <= '0;
            r_step_cnt   <= '0;
            r_soft_tmr   <= '0;
            r_req_cnt    <= '0;
            r_idx        <= '0;
            r_rst_out_n  <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b1;
            r_req_reject <= 1'b0;
            r_soft_cnt   <= '0;
        end else begin
            r_req_reject <= 1'b0;
            unique case (r_state)
                RESET: begin
                    if (w_sync_n) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state     <= SEQ;
                        r_rst_out_n <= N_CH'(1);
                        r_idx       <= IW'(1);
                        r_step_cnt  <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                SEQ: begin
                    if (r_step_cnt == STEP_LAST) begin
                        r_step_cnt <= '0;
                        if (r_idx == CH_N) begin
                            r_state   <= RUN;
                            r_valid   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_req_cnt <= '0;
                        end else begin
                            // Thermometer fill keeps released bits high.
                            r_rst_out_n <= (r_rst_out_n << 1)
                                         | N_CH'(1);
                            r_idx       <= r_idx + 1'b1;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (sw_rst_req) begin
                        if (r_req_cnt == REQ_LAST) begin
                            r_state     <= SOFT;
                            r_rst_out_n <= '0;
                            r_valid     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_req_cnt   <= '0;
                            r_soft_tmr  <= '0;
                            if (r_soft_cnt != '1) begin
                                r_soft_cnt <= r_soft_cnt + 1'b1;
                            end
                        end else begin
                            r_req_cnt <= r_req_cnt + 1'b1;
                        end
                    end else begin
                        if (r_req_cnt != '0) begin
                            r_req_reject <= 1'b1;
                        end
                        r_req_cnt <= '0;
                    end
                end
                SOFT: begin
                    if (r_soft_tmr == SOFT_LAST) begin
                        if (!sw_rst_req) begin
                            r_state    <= HOLD;
                            r_hold_cnt <= '0;
                        end
                    end else begin
                        r_soft_tmr <= r_soft_tmr + 1'b1;
                    end
                end
                default: begin
                    r_state <= RESET;
                end
            endcase
        end
    end

    assign rst_out_n  = r_rst_out_n;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign req_reject = r_req_reject;
    assign soft_cnt   = r_soft_cnt;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: default build plus a
// one-channel build, checked against release-time arithmetic.
module tb_rst_seq_ctrl;

    localparam int S  = 2;
    localparam int H  = 4;
    localparam int N  = 3;
    localparam int ST = 2;
    localparam int MR = 3;
    localparam int SC = 5;
    localparam int CW = 8;

    localparam int S2  = 3;
    localparam int N2  = 1;
    localparam int ST2 = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sw_rst_req = 1'b0;

    logic [N-1:0]  rst_out_n;
    logic          valid;
    logic          busy;
    logic          req_reject;
    logic [CW-1:0] soft_cnt;

    logic [N2-1:0] rst_out2_n;
    logic          valid2;
    logic          busy2;
    logic          rej2;
    logic [CW-1:0] soft_cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int m_soft   = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .SYNC_STAGES(S), .HOLD_CYCLES(H), .N_CH(N),
        .STEP_CYCLES(ST), .MIN_REQ(MR), .SOFT_CYCLES(SC),
        .CNT_W(CW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_rst_req(sw_rst_req),
        .rst_out_n (rst_out_n),
        .valid     (valid),
        .busy      (busy),
        .req_reject(req_reject),
        .soft_cnt  (soft_cnt)
    );

    rst_seq_ctrl #(
        .SYNC_STAGES(S2), .HOLD_CYCLES(H), .N_CH(N2),
        .STEP_CYCLES(ST2), .MIN_REQ(MR), .SOFT_CYCLES(SC),
        .CNT_W(CW)
    ) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_rst_req(sw_rst_req),
        .rst_out_n (rst_out2_n),
        .valid     (valid2),
        .busy      (busy2),
        .req_reject(rej2),
        .soft_cnt  (soft_cnt2)
    );

    // d = clock edges since HOLD was entered
    function automatic logic [7:0] exp_rst(
        input int d, input int h, input int n, input int st
    );
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (d >= h + i * st) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic exp_valid(
        input int d, input int h, input int n, input int st
    );
        return (d >= h + n * st);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        #12;
        n_checks++;
        if (rst_out_n !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_rst_out: got %b want 000", rst_out_n);
        end
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_valid_busy: got %b%b want 01",
                     valid, busy);
        end
        n_checks++;
        if (req_reject !== 1'b0 || soft_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_rej_cnt: got %b/%0d want 0/0",
                     req_reject, soft_cnt);
        end
        n_checks++;
        if (rst_out2_n !== 1'b0 || valid2 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_dut2: got %b/%b want 0/0",
                     rst_out2_n, valid2);
        end
    endtask

    task automatic test_powerup();
        logic [7:0] er;
        logic [7:0] er2;
        logic       ev;
        logic       ev2;
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            er  = exp_rst(k - S, H, N, ST);
            ev  = exp_valid(k - S, H, N, ST);
            er2 = exp_rst(k - S2, H, N2, ST2);
            ev2 = exp_valid(k - S2, H, N2, ST2);
            n_checks++;
            if (rst_out_n !== er[N-1:0] || valid !== ev ||
                busy !== !ev || req_reject !== 1'b0) begin
                n_errors++;
                $display("FAIL powerup edge %0d: got %b v%b b%b r%b want %b v%b b%b r0",
                         k, rst_out_n, valid, busy, req_reject,
                         er[N-1:0], ev, !ev);
            end
            n_checks++;
            if (rst_out2_n !== er2[0:0] || valid2 !== ev2) begin
                n_errors++;
                $display("FAIL powerup_dut2 edge %0d: got %b v%b want %b v%b",
                         k, rst_out2_n, valid2, er2[0:0], ev2);
            end
        end
    endtask

    // Request held high for L sampled edges starting from RUN.
    task automatic test_req_pulse(input int L, input string tag);
        logic [7:0] er;
        logic       ev;
        logic       erej;
        logic       acc;
        int         e;
        int         last;
        int         ecnt;
        int         cnt_now;
        acc  = (L >= MR);
        e    = 0;
        if (acc) begin
            e = (MR + SC > L + 1) ? MR + SC : L + 1;
        end
        last = acc ? e + H + N * ST + 1 : L + 2;
        ecnt = acc ? ((m_soft < 255) ? m_soft + 1 : 255) : m_soft;
        sw_rst_req = 1'b1;
        for (int j = 1; j <= last; j++) begin
            tick();
            if (j == L) sw_rst_req = 1'b0;
            if (!acc || j < MR) begin
                er = 8'hFF;
                ev = 1'b1;
            end else begin
                er = exp_rst(j - e, H, N, ST);
                ev = exp_valid(j - e, H, N, ST);
            end
            erej    = (!acc && j == L + 1);
            cnt_now = (acc && j >= MR) ? ecnt : m_soft;
            n_checks++;
            if (rst_out_n !== er[N-1:0] || valid !== ev ||
                busy !== !ev) begin
                n_errors++;
                $display("FAIL %s L=%0d edge %0d: got %b v%b b%b want %b v%b b%b",
                         tag, L, j, rst_out_n, valid, busy,
                         er[N-1:0], ev, !ev);
            end
            n_checks++;
            if (req_reject !== erej ||
                soft_cnt !== CW'(cnt_now)) begin
                n_errors++;
                $display("FAIL %s_rej_cnt L=%0d edge %0d: got %b/%0d want %b/%0d",
                         tag, L, j, req_reject, soft_cnt,
                         erej, cnt_now);
            end
        end
        m_soft = ecnt;
    endtask

    task automatic test_reject();
        for (int l = 1; l < MR; l++) begin
            test_req_pulse(l, "reject");
        end
    endtask

    task automatic test_soft_accept();
        test_req_pulse(MR, "accept");
    endtask

    task automatic test_soft_extend();
        test_req_pulse(10, "extend");
    endtask

    task automatic test_random();
        int l;
        int gap;
        for (int n = 0; n < 8; n++) begin
            l   = $urandom_range(1, 6);
            gap = $urandom_range(0, 3);
            test_req_pulse(l, "random");
            for (int g = 0; g < gap; g++) begin
                tick();
                n_checks++;
                if (valid !== 1'b1 || req_reject !== 1'b0 ||
                    rst_out_n !== 3'b111) begin
                    n_errors++;
                    $display("FAIL random_idle: got %b v%b r%b want 111 v1 r0",
                             rst_out_n, valid, req_reject);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] er;
        logic       ev;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rst_out_n !== 3'b000 || valid !== 1'b0 ||
            busy !== 1'b1 || soft_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL glitch_async: got %b v%b b%b c%0d want 000 v0 b1 c0",
                     rst_out_n, valid, busy, soft_cnt);
        end
        #2;
        rst_n  = 1'b1;
        m_soft = 0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            er = exp_rst(k - S, H, N, ST);
            ev = exp_valid(k - S, H, N, ST);
            n_checks++;
            if (rst_out_n !== er[N-1:0] || valid !== ev ||
                busy !== !ev || soft_cnt !== 8'd0) begin
                n_errors++;
                $display("FAIL glitch_seq edge %0d: got %b v%b b%b c%0d want %b v%b b%b c0",
                         k, rst_out_n, valid, busy, soft_cnt,
                         er[N-1:0], ev, !ev);
            end
        end
    endtask

    task automatic test_seq_ignore();
        logic [7:0] er;
        logic       ev;
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        #12;
        @(posedge clk);
        #4;
        rst_n  = 1'b1;
        m_soft = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 2) sw_rst_req = 1'b1;
            if (k == 9) sw_rst_req = 1'b0;
            er = exp_rst(k - S, H, N, ST);
            ev = exp_valid(k - S, H, N, ST);
            n_checks++;
            if (rst_out_n !== er[N-1:0] || valid !== ev ||
                req_reject !== 1'b0 || soft_cnt !== 8'd0) begin
                n_errors++;
                $display("FAIL seq_ignore edge %0d: got %b v%b r%b c%0d want %b v%b r0 c0",
                         k, rst_out_n, valid, req_reject, soft_cnt,
                         er[N-1:0], ev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_reject();
        test_soft_accept();
        test_soft_extend();
        test_random();
        test_glitch();
        test_seq_ignore();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
